bram_to_axis_mover: RTL and testbench

- Reads a contiguous block of words from a single-port BRAM, starting at address 0, and emits them as an AXI4-Stream master.
- It is the transmit end paired with the stream-side receive path; it feeds the core/DMA from on-chip memory.
- One run is started by a pulse on i_run carrying a word count.
- Honours m_axis_tready backpressure without losing or duplicating data, and marks the final beat with tlast.

---
 rtl/bram_to_axis_mover_pkg.sv | 12 +
 rtl/bram_to_axis_mover_skid_fifo.sv | 48 ++++
 rtl/bram_to_axis_mover.sv | 144 ++++++++++++++
 tb/tb_bram_to_axis_mover.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_to_axis_mover_pkg.sv
// Shared definitions for the BRAM <-> AXI4-Stream mover paths.
package bram_to_axis_mover_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int unsigned FIFO_DEPTH_DEFAULT = 2;

endpackage

// File: rtl/bram_to_axis_mover_skid_fifo.sv
// axis_skid_fifo: small synchronous FIFO holding read data ahead of the stream port.
module axis_skid_fifo #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned DEPTH  = 2,
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned OW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    input  logic              pop,
    output logic [DWIDTH-1:0] head,
    output logic [OW-1:0]     occ
);

    logic [DWIDTH-1:0] slots [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                slots[wr_ptr] <= push_data;
                wr_ptr        <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            occ <= occ + OW'(push) - OW'(pop);
        end
    end

    assign head = slots[rd_ptr];

endmodule

// File: rtl/bram_to_axis_mover.sv
// Streams words 0..num_cnt-1 of a single-port BRAM out as an AXI4-Stream master.
module bram_to_axis_mover
    import bram_to_axis_mover_pkg::*;
#(
    parameter int unsigned DWIDTH     = 32,
    parameter int unsigned AWIDTH     = 12,
    parameter int unsigned MEM_SIZE   = 4096,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_run,
    // one extra bit so that a full-memory run (MEM_SIZE words) is expressible
    input  logic [AWIDTH:0]   i_num_cnt,
    output logic              o_idle,
    output logic              o_run,
    output logic              o_done,
    output logic [AWIDTH-1:0] addr_b0,
    output logic              ce_b0,
    output logic              we_b0,
    output logic [DWIDTH-1:0] d_b0,
    input  logic [DWIDTH-1:0] q_b0,
    output logic [DWIDTH-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast
);

    localparam int unsigned     OW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [AWIDTH:0] CNT_ONE = (AWIDTH + 1)'(1);
    localparam logic [AWIDTH:0] MAX_CNT = (AWIDTH + 1)'(MEM_SIZE);

    state_t            state, state_nx;
    logic [AWIDTH:0]   num_cnt;
    logic [AWIDTH:0]   rd_cnt;
    logic [AWIDTH:0]   tx_cnt;
    logic              inflight;
    logic              pop;
    logic              last_beat;
    logic [OW:0]       outstanding;
    logic              fifo_push;
    logic              fifo_pop;
    logic [DWIDTH-1:0] fifo_head;
    logic [OW-1:0]     fifo_occ;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        ce_b0       = 1'b0;
        outstanding = (OW + 1)'(fifo_occ) + (OW + 1)'(inflight) - (OW + 1)'(pop);
        case (state)
            S_IDLE: begin
                if (i_run) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                ce_b0 = (rd_cnt < num_cnt) && (outstanding < (OW + 1)'(FIFO_DEPTH));
                if ((num_cnt == '0) || (pop && last_beat)) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_cnt  <= '0;
            rd_cnt   <= '0;
            tx_cnt   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= ce_b0;
            case (state)
                S_IDLE: begin
                    if (i_run) begin
                        num_cnt <= i_num_cnt;
                    end
                end
                S_RUN: begin
                    if (ce_b0) begin
                        rd_cnt <= rd_cnt + CNT_ONE;
                    end
                    if (pop) begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                default: begin
                    rd_cnt <= '0;
                    tx_cnt <= '0;
                end
            endcase
        end
    end

    // A word returning from BRAM is offered straight away when the FIFO is
    // empty; it is only stored if that same cycle does not consume it.
    assign m_axis_tvalid = (fifo_occ != '0) || inflight;
    assign m_axis_tdata  = (fifo_occ != '0) ? fifo_head :
                           (inflight ? q_b0 : '0);
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign fifo_pop      = pop && (fifo_occ != '0);
    assign fifo_push     = inflight && !(pop && (fifo_occ == '0));
    assign last_beat     = (tx_cnt == (num_cnt - CNT_ONE));
    assign m_axis_tlast  = m_axis_tvalid && last_beat;

    axis_skid_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (state == S_DONE),
        .push      (fifo_push),
        .push_data (q_b0),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .occ       (fifo_occ)
    );

    assign addr_b0 = rd_cnt[AWIDTH-1:0];
    assign we_b0   = 1'b0;
    assign d_b0    = '0;
    assign o_idle  = (state == S_IDLE);
    assign o_run   = (state == S_RUN);
    assign o_done  = (state == S_DONE);

    assert property (@(posedge clk) disable iff (!reset_n)
        ((state == S_IDLE) && i_run) |-> (i_num_cnt <= MAX_CNT));

endmodule

// File: tb/tb_bram_to_axis_mover.sv
// Scoreboard bench for bram_to_axis_mover with a behavioural BRAM and stream model.
module tb_bram_to_axis_mover;

    typedef struct {
        logic [31:0] data;
        bit          last;
        int          cyc;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_run;
    logic [12:0] i_num_cnt;
    logic        o_idle, o_run, o_done;
    logic [11:0] addr_b0;
    logic        ce_b0, we_b0;
    logic [31:0] d_b0;
    logic [31:0] q_b0 = '0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;

    logic [31:0] mem [4096];
    beat_t       exp_q [$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          rd_seen = 0;
    int          hs_run = 0;
    int          exp_reads = 0;
    int          rmode = 0;
    int          pidx = 0;
    bit          pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    bram_to_axis_mover #(
        .DWIDTH     (32),
        .AWIDTH     (12),
        .MEM_SIZE   (4096),
        .FIFO_DEPTH (2)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_run         (i_run),
        .i_num_cnt     (i_num_cnt),
        .o_idle        (o_idle),
        .o_run         (o_run),
        .o_done        (o_done),
        .addr_b0       (addr_b0),
        .ce_b0         (ce_b0),
        .we_b0         (we_b0),
        .d_b0          (d_b0),
        .q_b0          (q_b0),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // single-port BRAM: registered read, one cycle latency
    always @(posedge clk) begin
        if (ce_b0) q_b0 <= mem[addr_b0];
    end

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1: begin m_axis_tready = pat[pidx % 6]; pidx++; end
                2: m_axis_tready = 1'($urandom_range(0, 1));
                default: m_axis_tready = 1'b1;
            endcase
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // monitor: checks every presented beat against the scoreboard queue
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                total++;
                if (!(m_axis_tvalid && m_axis_tdata == prev_data)) begin
                    bad++;
                    $display("FAIL hold: tvalid=%0b tdata=%h required tvalid=1 tdata=%h",
                             m_axis_tvalid, m_axis_tdata, prev_data);
                end
            end
            if (m_axis_tvalid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_beat: tdata=%h with no beat expected", m_axis_tdata);
                end else begin
                    total++;
                    if (m_axis_tdata !== exp_q[0].data || m_axis_tlast !== exp_q[0].last) begin
                        bad++;
                        $display("FAIL beat: tdata=%h tlast=%0b required tdata=%h tlast=%0b",
                                 m_axis_tdata, m_axis_tlast, exp_q[0].data, exp_q[0].last);
                    end
                    if (m_axis_tready) begin
                        if (exp_q[0].cyc >= 0) begin
                            total++;
                            if (cyc != exp_q[0].cyc) begin
                                bad++;
                                $display("FAIL beat_cycle: handshake at %0d required %0d",
                                         cyc, exp_q[0].cyc);
                            end
                        end
                        void'(exp_q.pop_front());
                    end
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            if (ce_b0) begin
                total++;
                if (rd_seen >= exp_reads || addr_b0 != rd_seen[11:0]) begin
                    bad++;
                    $display("FAIL read: addr=%h read#%0d required addr=%h of %0d reads",
                             addr_b0, rd_seen, rd_seen[11:0], exp_reads);
                end
                rd_seen++;
            end
            if (m_axis_tvalid && m_axis_tready) hs_run++;
            total++;
            if (rd_seen - hs_run > 2) begin
                bad++;
                $display("FAIL outstanding: %0d words required <= 2", rd_seen - hs_run);
            end
        end
    end

    task automatic start_run(input int n, input bit timed, output int c0);
        beat_t b;
        @(posedge clk);
        #1;
        c0 = cyc;
        exp_q.delete();
        rd_seen   = 0;
        hs_run    = 0;
        exp_reads = n;
        for (int i = 0; i < n; i++) begin
            b.data = mem[i];
            b.last = (i == n - 1);
            b.cyc  = timed ? c0 + 2 + i : -1;
            exp_q.push_back(b);
        end
        i_num_cnt = 13'(n);
        i_run     = 1'b1;
        @(posedge clk);
        #1;
        i_run     = 1'b0;
        i_num_cnt = '0;
    endtask

    task automatic wait_done(input int exp_cyc);
        bit got = 1'b0;
        int n = 0;
        while (!got && n < 10000) begin
            @(negedge clk);
            n++;
            if (o_done) got = 1'b1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL done_timeout: o_done not seen within %0d cycles", n);
        end else if (exp_cyc >= 0 && cyc != exp_cyc) begin
            bad++;
            $display("FAIL done_cycle: o_done at %0d required %0d", cyc, exp_cyc);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL beats_left: %0d beats undelivered required 0", exp_q.size());
        end
        @(negedge clk);
        total++;
        if (!(o_idle && !o_done && !o_run)) begin
            bad++;
            $display("FAIL back_idle: idle=%0b done=%0b run=%0b required 1 0 0", o_idle, o_done, o_run);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        total++;
        if ({o_idle, o_run, o_done, ce_b0, we_b0, m_axis_tvalid, m_axis_tlast} !== 7'b1000000 ||
            addr_b0 !== '0 || m_axis_tdata !== '0 || d_b0 !== '0) begin
            bad++;
            $display("FAIL %s: idle/run/done/ce/we/tvalid/tlast=%b addr=%h tdata=%h required 1000000 0 0",
                     name, {o_idle, o_run, o_done, ce_b0, we_b0, m_axis_tvalid, m_axis_tlast},
                     addr_b0, m_axis_tdata);
        end
    endtask

    initial begin
        int c0;
        int n;
        int m;
        bit hit;
        reset_n   = 1'b0;
        i_run     = 1'b0;
        i_num_cnt = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'(i + 32'h100);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        @(posedge clk);
        #2;
        reset_n = 1'b1;

        rmode = 0;
        start_run(8, 1'b1, c0);
        wait_done(c0 + 8 + 2);

        rmode = 1;
        pidx  = 0;
        start_run(5, 1'b0, c0);
        wait_done(-1);

        rmode = 0;
        start_run(1, 1'b1, c0);
        wait_done(c0 + 1 + 2);
        start_run(0, 1'b1, c0);
        wait_done(c0 + 2);

        start_run(6, 1'b1, c0);
        @(posedge clk);
        #1;
        i_run     = 1'b1;
        i_num_cnt = 13'd3;
        @(posedge clk);
        #1;
        i_run     = 1'b0;
        i_num_cnt = '0;
        wait_done(c0 + 6 + 2);

        start_run(4096, 1'b1, c0);
        wait_done(c0 + 4096 + 2);

        start_run(8, 1'b0, c0);
        hit = 1'b0;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(posedge clk);
            if (hs_run >= 3) hit = 1'b1;
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL reset_wait: handshakes=%0d required 3", hs_run);
        end
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_run_reset");
        exp_q.delete();
        exp_reads = 0;
        rd_seen   = 0;
        hs_run    = 0;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        start_run(2, 1'b1, c0);
        wait_done(c0 + 2 + 2);

        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        for (int r = 0; r < 10; r++) begin
            m     = int'($urandom_range(0, 2));
            n     = int'($urandom_range(0, 40));
            rmode = m;
            pidx  = 0;
            start_run(n, m == 0, c0);
            wait_done((m == 0) ? c0 + n + 2 : -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
